// File: rtl/dw_lod_scan.sv
// Sequential leading-one / leading-zero scanner: accepts a vector and walks
// every target bit MSB first, one beat per bit, with one-hot, count and ordinal.
module dw_lod_scan #(
   parameter int a_width    = 8,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [a_width-1:0]    in_data,
   input  logic                  in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [a_width-1:0]    out_dec,
   output logic [addr_width-1:0] out_enc,
   output logic [addr_width-1:0] out_idx,
   output logic                  out_last,
   output logic                  out_empty
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   function automatic logic [a_width-1:0] msb_onehot(input logic [a_width-1:0] v);
      logic [a_width-1:0] r;
      logic               found;
      r     = '0;
      found = 1'b0;
      for (int i = a_width - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            r[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [addr_width-1:0] lead_zeros(input logic [a_width-1:0] v);
      logic [addr_width-1:0] r;
      logic                  found;
      r     = addr_width'(a_width);
      found = 1'b0;
      for (int i = a_width - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            r     = addr_width'(a_width - 1 - i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic single_bit(input logic [a_width-1:0] v);
      return (v != '0) && ((v & (v - a_width'(1))) == '0);
   endfunction

   logic [0:0]            state_r, state_nxt_s;
   logic [a_width-1:0]    work_r, work_nxt_s, loaded_s;
   logic [addr_width-1:0] idx_r, idx_nxt_s;
   logic                  empty_r, empty_nxt_s;
   logic [a_width-1:0]    out_dec_r;
   logic [addr_width-1:0] out_enc_r;
   logic                  out_last_r, out_empty_r;
   logic                  accept_s, beat_s;

   assign out_valid = (state_r == SCAN);
   assign out_dec   = out_dec_r;
   assign out_enc   = out_enc_r;
   assign out_idx   = idx_r;
   assign out_last  = out_last_r;
   assign out_empty = out_empty_r;

   // A new vector may follow the last beat on the same edge, hence the out_ready path.
   assign in_ready = rst_n & ((state_r == IDLE) | (out_valid & out_ready & out_last_r));
   assign accept_s = in_valid & in_ready;
   assign beat_s   = out_valid & out_ready;
   assign loaded_s = in_mode ? ~in_data : in_data;

   // Next-state selection for the scan registers
   always_comb begin
      state_nxt_s = state_r;
      work_nxt_s  = work_r;
      idx_nxt_s   = idx_r;
      empty_nxt_s = empty_r;
      if (accept_s) begin
         state_nxt_s = SCAN;
         work_nxt_s  = loaded_s;
         idx_nxt_s   = '0;
         empty_nxt_s = (loaded_s == '0);
      end else if (beat_s) begin
         if (out_last_r) begin
            state_nxt_s = IDLE;
            work_nxt_s  = '0;
            idx_nxt_s   = '0;
            empty_nxt_s = 1'b0;
         end else begin
            work_nxt_s = work_r & ~out_dec_r;
            idx_nxt_s  = idx_r + addr_width'(1);
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and registered beat outputs, precomputed from the next work vector
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         work_r      <= '0;
         idx_r       <= '0;
         empty_r     <= 1'b0;
         out_dec_r   <= '0;
         out_enc_r   <= addr_width'(a_width);
         out_last_r  <= 1'b0;
         out_empty_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         work_r      <= work_nxt_s;
         idx_r       <= idx_nxt_s;
         empty_r     <= empty_nxt_s;
         out_dec_r   <= msb_onehot(work_nxt_s);
         out_enc_r   <= lead_zeros(work_nxt_s);
         out_last_r  <= (state_nxt_s == SCAN) & (single_bit(work_nxt_s) | empty_nxt_s);
         out_empty_r <= (state_nxt_s == SCAN) & empty_nxt_s;
      end
   end

endmodule

// File: tb/tb_dw_lod_scan.sv
// Self-checking bench for dw_lod_scan: directed scenarios plus random traffic
// scored against a queue of expected beats derived from each accepted vector.
module tb_dw_lod_scan;

   localparam int AW = 8;
   localparam int NW = 4;

   typedef struct {
      logic [AW-1:0] dec;
      logic [NW-1:0] enc;
      logic [NW-1:0] idx;
      logic          last;
      logic          empty;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_data = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_dec;
   logic [NW-1:0] out_enc;
   logic [NW-1:0] out_idx;
   logic          out_last;
   logic          out_empty;

   int            n_chk = 0;
   int            n_fail = 0;
   beat_t         exp_q[$];
   logic [AW:0]   stim_q[$];
   logic          acc_prev = 1'b0;

   dw_lod_scan #(.a_width(AW), .addr_width(NW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_dec(out_dec), .out_enc(out_enc),
      .out_idx(out_idx), .out_last(out_last), .out_empty(out_empty)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference: list every target bit of the vector, highest first.
   task automatic push_expected(input logic mode, input logic [AW-1:0] d);
      logic [AW-1:0] w;
      int            total;
      int            k;
      beat_t         b;
      w = mode ? ~d : d;
      total = $countones(w);
      if (total == 0) begin
         b.dec = '0; b.enc = NW'(AW); b.idx = '0; b.last = 1'b1; b.empty = 1'b1;
         exp_q.push_back(b);
      end else begin
         k = 0;
         for (int i = AW - 1; i >= 0; i--) begin
            if (w[i]) begin
               b.dec = AW'(1) << i;
               b.enc = NW'(AW - 1 - i);
               b.idx = NW'(k);
               b.last = (k == total - 1);
               b.empty = 1'b0;
               exp_q.push_back(b);
               k++;
            end
         end
      end
   endtask

   task automatic step(input logic rdy);
      logic exp_ready;
      @(negedge clk);
      if (acc_prev) in_valid = 1'b0;
      acc_prev = 1'b0;
      if (!in_valid && stim_q.size() > 0) begin
         in_valid = 1'b1;
         {in_mode, in_data} = stim_q[0];
      end
      out_ready = rdy;
      #1;
      check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check_val("out_dec", 32'(out_dec), 32'(exp_q[0].dec));
         check_val("out_enc", 32'(out_enc), 32'(exp_q[0].enc));
         check_val("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
         check_val("out_last", 32'(out_last), 32'(exp_q[0].last));
         check_val("out_empty", 32'(out_empty), 32'(exp_q[0].empty));
      end
      exp_ready = (exp_q.size() == 0) || (rdy && exp_q[0].last);
      check_val("in_ready", 32'(in_ready), 32'(exp_ready));
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
         push_expected(in_mode, in_data);
         void'(stim_q.pop_front());
         acc_prev = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      acc_prev = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1;
      check_val("rst in_ready", 32'(in_ready), 32'd0);
      check_val("rst out_valid", 32'(out_valid), 32'd0);
      check_val("rst out_dec", 32'(out_dec), 32'd0);
      check_val("rst out_enc", 32'(out_enc), 32'(AW));
      check_val("rst out_idx", 32'(out_idx), 32'd0);
      check_val("rst out_last", 32'(out_last), 32'd0);
      check_val("rst out_empty", 32'(out_empty), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || stim_q.size() != 0 || in_valid) && budget < 200) begin
         step(1'b1);
         budget++;
      end
      check_val("drain timeout", 32'(budget >= 200), 32'd0);
      step(1'b1);
   endtask

   initial begin
      do_reset();
      // basic LOD, both empty flavours, LZD
      stim_q.push_back({1'b0, 8'b1010_0100});
      drain();
      stim_q.push_back({1'b0, 8'h00});
      stim_q.push_back({1'b1, 8'hFF});
      drain();
      stim_q.push_back({1'b1, 8'b1111_0110});
      drain();
      // backpressure on beat 1 with a vector pending upstream
      stim_q.push_back({1'b0, 8'hC1});
      stim_q.push_back({1'b0, 8'h3C});
      step(1'b1);
      step(1'b1);
      for (int i = 0; i < 3; i++) step(1'b0);
      drain();
      // back-to-back vectors without an idle cycle
      stim_q.push_back({1'b0, 8'h81});
      stim_q.push_back({1'b0, 8'h10});
      drain();
      // reset mid-scan
      stim_q.push_back({1'b0, 8'hFF});
      step(1'b1);
      step(1'b1);
      do_reset();
      stim_q.push_back({1'b0, 8'h02});
      drain();
      // random traffic
      for (int n = 0; n < 600; n++) begin
         if (stim_q.size() < 2 && $urandom_range(0, 2) != 0) begin
            case ($urandom_range(0, 4))
               0: stim_q.push_back({1'($urandom_range(0, 1)), 8'h00});
               1: stim_q.push_back({1'($urandom_range(0, 1)), 8'hFF});
               default: stim_q.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
            endcase
         end
         step(1'($urandom_range(0, 3) != 0));
      end
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dw_lod_scan.md
Name: dw_lod_scan

Overview:
- Sequential leading-one / leading-zero scanner and the parametrised successor of the combinational LOD/LOD-encoder function pair.
- Accepts a vector through a valid/ready handshake, then emits one beat per target bit, MSB first. Each beat carries the one-hot decode, the leading-count encode and the beat ordinal.
- Used by normalisation, priority-arbitration and free-list logic that must walk every set (or clear) bit, not only the first.

Parameters:
- a_width, 8, data vector width; legal range ≥2.
- addr_width, 4, encode/ordinal width; must be ≥ ceil(log2(a_width+1)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  vector offered.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  a_width  vector to scan.
- in_mode  input  1  0 = scan ones (LOD), 1 = scan zeros (LZD); sampled with in_data.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_dec  output  a_width  one-hot of current target bit; 0 on empty beat.
- out_enc  output  addr_width  leading count = a_width-1-bit_index; a_width on empty beat.
- out_idx  output  addr_width  beat ordinal within the current vector, starting at 0.
- out_last  output  1  final beat of the current vector.
- out_empty  output  1  vector had no target bits.

Behaviour:
- State: IDLE, SCAN.
- Registers:
  - work[a_width-1:0]: in_data if in_mode=0, else ~in_data.
  - idx counter.
  - empty flag.
- Reset (rst_n=0 at edge): state=IDLE, work=0, idx=0, empty=0.
  - Outputs after reset: out_valid=0, out_dec=0, out_enc=a_width, out_idx=0, out_last=0, out_empty=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after reset deasserts.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last); this is combinational from out_ready.
- Accept (in_valid & in_ready at edge):
  - Load work from in_data/in_mode as above.
  - idx=0.
  - empty = (work==0).
  - Next state SCAN.
  - Latency: first beat has out_valid=1 in the cycle immediately after the accept edge.
- In SCAN:
  - out_valid=1.
  - out_dec = one-hot of the highest set bit of work.
  - out_enc = count of leading zeros of work.
  - out_last = (work has exactly one set bit) | empty.
  - out_empty = empty.
  - All out_* are driven from registers only; out_ready does not affect them.
- Beat handshake (out_valid & out_ready):
  - If not last: clear the emitted bit in work, idx += 1, stay in SCAN.
  - If last: state→IDLE, unless a new vector is accepted on the same edge. In that case, load the new vector and stay in SCAN. There is no bubble; sustained throughput is one beat per cycle.
- Backpressure: while out_valid & !out_ready, all out_* hold stable and in_ready=0.
- Empty vector (all zeros for mode 0, all ones for mode 1): exactly one beat with out_empty=1, out_last=1, out_dec=0, out_enc=a_width, out_idx=0.
- Full vector: a_width beats; out_idx runs 0..a_width-1.
- in_valid while in_ready=0 is ignored. The upstream must hold in_data/in_mode stable until accepted.
- Reset mid-scan: remaining beats are discarded and no partial beat is emitted after the reset edge.
- No arithmetic overflow is possible: idx ≤ a_width-1 and enc ≤ a_width, both within addr_width.

Test Plan:
1. Basic LOD: mode=0, in_data=8'b1010_0100, out_ready=1.
   - Beats: dec 0x80/0x20/0x04, enc 0/2/5, idx 0/1/2.
   - out_last only on the third beat; out_valid=0 after it.
2. Empty vectors:
   - mode=0, 8'h00 → one beat: empty=1, last=1, dec=0, enc=8, idx=0.
   - mode=1, 8'hFF → identical response.
3. LZD: mode=1, in_data=8'b1111_0110.
   - Beats: dec 0x08/0x01, enc 4/7, last on the second beat.
4. Backpressure: 8'hC1, out_ready=0 for 3 cycles on beat 1.
   - dec=0x40, enc=1, idx=1 held stable; in_ready=0 throughout.
   - A pending in_valid is not accepted; beats resume unchanged.
5. Back-to-back: in_valid held with 8'h81 then 8'h10.
   - The second vector is accepted on the edge of the last beat of the first.
   - Its beat (dec=0x10, enc=3, idx=0, last=1) is valid the next cycle with no idle cycle.
6. Reset mid-scan: 8'hFF mode=0; rst_n=0 for one edge after beat 0.
   - Next cycle: out_valid=0, in_ready=1.
   - A new vector 8'h02 yields a single beat: enc=6, idx=0.
